if_id_buffer: RTL and testbench
===============================

# if_id_buffer

Instruction buffer and pre-decode stage between the fetch unit and the decode/execute stage. It captures {pc, instruction} pairs from fetch in a small FIFO with a valid/ready handshake on both sides, and absorbs decode-side stalls without dropping instructions. For the head entry it presents pre-decoded register fields, sign-extended immediates and one-hot branch/jump flags, in the form the fetch unit's branch inputs consume. A single-cycle flush discards all buffered entries on a taken branch or jump.

## Interface
Parameters:
- DEPTH, 2: number of buffered entries; power of two, ≥2.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  discard all entries and any same-cycle push
- in_valid  in  1  fetch offers an entry
- in_pc  in  32  PC of offered instruction
- in_instr  in  32  instruction word
- in_ready  out  1  buffer accepts an entry this cycle
- out_valid  out  1  head entry available
- out_ready  in  1  downstream takes head this cycle
- out_pc  out  32  head PC
- out_instr  out  32  head instruction
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], [19:15], [24:20]
- out_funct3  out  3  instr[14:12]
- out_imm_b  out  32  sign-extended B-type byte offset
- out_imm_j  out  32  sign-extended J-type byte offset
- beq, bneq, blt, bltu, bge, bgeu, jmp  out  1 each  head-entry instruction-class flags
- out_illegal  out  1  head opcode is not RV32I base
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: circular FIFO with rd_ptr and wr_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus count.
- Push = in_valid & in_ready & ~flush. Pop = out_valid & out_ready & ~flush.
- in_ready = (count < DEPTH). It depends only on registered state, never on out_ready.
- out_valid = (count != 0).
- Push only: write at wr_ptr, wr_ptr+1, count+1. Pop only: rd_ptr+1, count−1. Push and pop together: both pointers advance and count is unchanged.
- Flush (priority over push/pop): next cycle rd_ptr = wr_ptr = count = 0, and any same-cycle push is discarded.
- Reset: same as flush. Storage contents are don't-care.
- Decode acts combinationally on the head entry. With op = out_instr[6:0] and f3 = out_funct3:
  - op 1100011 with f3 000/001/100/101/110/111 → beq/bneq/blt/bge/bltu/bgeu respectively.
  - op 1100011 with f3 010/011 → out_illegal.
  - op 1101111 (JAL) or 1100111 (JALR) → jmp.
  - Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011. Any other opcode → out_illegal.
- Immediates:
  - out_imm_b = sign-extend {i[31], i[7], i[30:25], i[11:8], 1'b0}.
  - out_imm_j = sign-extend {i[31], i[19:12], i[20], i[30:21], 1'b0}.
- All decoded outputs, out_pc and out_instr are forced to 0 when out_valid = 0. At most one branch/jmp flag is high at a time.

## Timing
- After reset: out_valid = 0, count = 0, in_ready = 1 when DEPTH ≥ 1, all data/flag outputs = 0.
- Latency: an entry pushed at edge N appears on out_* in the cycle after edge N. There is no combinational in→out bypass.
- Throughput: 1 entry per cycle sustained while out_ready = 1.
- Full (count = DEPTH): in_ready = 0 even if out_ready = 1 in the same cycle. Fetch must hold in_valid/in_pc/in_instr stable until accepted.
- Empty: out_ready is ignored and nothing changes.
- out_* stay stable while out_valid = 1 and out_ready = 0.
- Flush asserted at edge N: out_valid = 0 in the cycle after N. A push offered at edge N+1 is accepted normally.
- Reset mid-stream has the same effect as flush, and reset overrides flush.
- Pointer wrap: after DEPTH pushes wr_ptr returns to 0. The FIFO must stay ordered across the wrap.

## Test plan
- Reset, then push pc 0x0, 0x4, 0x8 (instr 0x00000013 each) with out_ready = 1 → out_pc sequence 0x0, 0x4, 0x8, each one cycle after its push. count never exceeds 1.
- Hold out_ready = 0 and offer 3 entries → count = 2, in_ready = 0, third entry held. Release out_ready → entries drain in order, the third is accepted, count returns to 0 with no loss or duplication.
- Head instr 0xFE000EE3 (beq x0, x0, −4) → beq = 1, out_imm_b = 0xFFFFFFFC. Head 0x0080006F (jal x0, +8) → jmp = 1, out_imm_j = 0x00000008. Head 0x00002063 (f3 010) → out_illegal = 1 and no branch flag.
- With count = 2, assert flush while in_valid = 1 → next cycle count = 0 and out_valid = 0, and the offered entry is absent. The next push appears normally.
- Stream 10 entries with random out_ready stalls → output order equals input order across pointer wraparound. At each edge count equals pushes minus pops.
- Assert reset mid-stream with count = 1 → next cycle all outputs are 0 and in_ready = 1.

Source files
------------

// File: rtl/if_id_buffer.sv
// if_id_buffer
//
// Instruction buffer and pre-decode stage sitting between fetch and
// decode/execute. Captures {pc, instruction} pairs in a small circular FIFO
// with valid/ready handshakes on both sides. The head entry is presented
// together with pre-decoded register fields, sign-extended B/J immediates
// and one-hot branch/jump class flags. A flush empties the buffer in one
// cycle and drops any push offered in the same cycle.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   flush                 discard all entries and any same-cycle push
//   in_valid/in_ready     fetch-side handshake
//   in_pc, in_instr       offered {pc, instruction}
//   out_valid/out_ready   decode-side handshake
//   out_pc, out_instr     head entry (0 when empty)
//   out_rd/rs1/rs2        register fields of head instruction
//   out_funct3            funct3 field of head instruction
//   out_imm_b, out_imm_j  sign-extended B-type / J-type byte offsets
//   beq..bgeu, jmp        head instruction class flags (at most one high)
//   out_illegal           head opcode is not RV32I base (or bad branch funct3)
//   count                 current occupancy
module if_id_buffer #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,

    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     in_ready,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [2:0]               out_funct3,
    output logic [31:0]              out_imm_b,
    output logic [31:0]              out_imm_j,
    output logic                     beq,
    output logic                     bneq,
    output logic                     blt,
    output logic                     bltu,
    output logic                     bge,
    output logic                     bgeu,
    output logic                     jmp,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    // RV32I base opcodes
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q,  count_d;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic push;
    logic pop;

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count_q < DepthCnt);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed when count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= in_pc;
            instr_mem[wr_ptr_q] <= in_instr;
        end
    end

    // ------------------------------------------------------------------
    // Head-entry pre-decode
    // ------------------------------------------------------------------
    logic [31:0] head_pc;
    logic [31:0] head_instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;

    // Gating the head to zero makes every derived field zero when empty.
    always_comb begin
        head_pc    = '0;
        head_instr = '0;
        if (out_valid) begin
            head_pc    = pc_mem[rd_ptr_q];
            head_instr = instr_mem[rd_ptr_q];
        end
    end

    assign opcode = head_instr[6:0];
    assign funct3 = head_instr[14:12];

    assign out_pc     = head_pc;
    assign out_instr  = head_instr;
    assign out_rd     = head_instr[11:7];
    assign out_rs1    = head_instr[19:15];
    assign out_rs2    = head_instr[24:20];
    assign out_funct3 = funct3;

    assign out_imm_b = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                        head_instr[30:25], head_instr[11:8], 1'b0};
    assign out_imm_j = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                        head_instr[20], head_instr[30:21], 1'b0};

    always_comb begin
        beq         = 1'b0;
        bneq        = 1'b0;
        blt         = 1'b0;
        bltu        = 1'b0;
        bge         = 1'b0;
        bgeu        = 1'b0;
        jmp         = 1'b0;
        out_illegal = 1'b0;
        // Opcode 0 would otherwise decode as illegal on an empty buffer.
        if (out_valid) begin
            case (opcode)
                OpBranch: begin
                    case (funct3)
                        3'b000:  beq         = 1'b1;
                        3'b001:  bneq        = 1'b1;
                        3'b100:  blt         = 1'b1;
                        3'b101:  bge         = 1'b1;
                        3'b110:  bltu        = 1'b1;
                        3'b111:  bgeu        = 1'b1;
                        default: out_illegal = 1'b1;
                    endcase
                end
                OpJal, OpJalr: begin
                    jmp = 1'b1;
                end
                OpLui, OpAuipc, OpLoad, OpStore, OpImm, OpReg, OpFence, OpSystem: begin
                    out_illegal = 1'b0;
                end
                default: begin
                    out_illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CntW  = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic [31:0]     in_pc;
    logic [31:0]     in_instr;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_pc;
    logic [31:0]     out_instr;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [31:0]     out_imm_b;
    logic [31:0]     out_imm_j;
    logic            beq, bneq, blt, bltu, bge, bgeu, jmp, out_illegal;
    logic [CntW-1:0] count;

    if_id_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_funct3  (out_funct3),
        .out_imm_b   (out_imm_b),
        .out_imm_j   (out_imm_j),
        .beq         (beq),
        .bneq        (bneq),
        .blt         (blt),
        .bltu        (bltu),
        .bge         (bge),
        .bgeu        (bgeu),
        .jmp         (jmp),
        .out_illegal (out_illegal),
        .count       (count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit sb_en    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard: entries queued when accepted, compared when popped.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t sbq[$];

    always @(negedge clk) begin
        if (sb_en) begin
            chk("sb_count", 32'(count), 32'(sbq.size()));
            chk("sb_out_valid", 32'(out_valid), 32'(sbq.size() != 0));
            chk("sb_in_ready", 32'(in_ready), 32'(sbq.size() < DEPTH));
            if (reset || flush) begin
                sbq.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_pop: got pop with nothing expected");
                    end else begin
                        ent_t e;
                        e = sbq.pop_front();
                        chk("sb_out_pc", out_pc, e.pc);
                        chk("sb_out_instr", out_instr, e.instr);
                    end
                end
                if (in_valid && in_ready) begin
                    sbq.push_back('{pc: in_pc, instr: in_instr});
                end
            end
        end
    end

    // Offer an entry and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: pc 0x%08h not accepted", pc);
        end
    endtask

    task automatic wait_empty(input string name);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (count == 0) break;
        end
        chk(name, 32'(count), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Decode vectors
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] instr;
        logic [7:0]  flags;   // {beq,bneq,blt,bltu,bge,bgeu,jmp,illegal}
        logic [31:0] imm_b;
        logic [31:0] imm_j;
        logic [17:0] fields;  // {rd,rs1,rs2,funct3}
    } vec_t;

    localparam int NV = 14;
    vec_t vec[NV];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit prod_done;

        vec[0]  = '{32'h00000013, 8'b0000_0000, 32'h00000000, 32'h00000000, {5'd0, 5'd0, 5'd0, 3'd0}};
        vec[1]  = '{32'hFE000EE3, 8'b1000_0000, 32'hFFFFFFFC, 32'hFFF007E0, {5'd29, 5'd0, 5'd0, 3'd0}};
        vec[2]  = '{32'h0080006F, 8'b0000_0010, 32'h00000000, 32'h00000008, {5'd0, 5'd0, 5'd8, 3'd0}};
        vec[3]  = '{32'h00002063, 8'b0000_0001, 32'h00000000, 32'h00002000, {5'd0, 5'd0, 5'd0, 3'd2}};
        vec[4]  = '{32'h00209463, 8'b0100_0000, 32'h00000008, 32'h00009002, {5'd8, 5'd1, 5'd2, 3'd1}};
        vec[5]  = '{32'h00004063, 8'b0010_0000, 32'h00000000, 32'h00004000, {5'd0, 5'd0, 5'd0, 3'd4}};
        vec[6]  = '{32'h00005063, 8'b0000_1000, 32'h00000000, 32'h00005000, {5'd0, 5'd0, 5'd0, 3'd5}};
        vec[7]  = '{32'h00006063, 8'b0001_0000, 32'h00000000, 32'h00006000, {5'd0, 5'd0, 5'd0, 3'd6}};
        vec[8]  = '{32'h00007063, 8'b0000_0100, 32'h00000000, 32'h00007000, {5'd0, 5'd0, 5'd0, 3'd7}};
        vec[9]  = '{32'h00003063, 8'b0000_0001, 32'h00000000, 32'h00003000, {5'd0, 5'd0, 5'd0, 3'd3}};
        vec[10] = '{32'h00008067, 8'b0000_0010, 32'h00000000, 32'h00008000, {5'd0, 5'd1, 5'd0, 3'd0}};
        vec[11] = '{32'hFFDFF06F, 8'b0000_0010, 32'hFFFFF7E0, 32'hFFFFFFFC, {5'd0, 5'd31, 5'd29, 3'd7}};
        vec[12] = '{32'h0000007F, 8'b0000_0001, 32'h00000000, 32'h00000000, {5'd0, 5'd0, 5'd0, 3'd0}};
        vec[13] = '{32'h00002083, 8'b0000_0000, 32'h00000800, 32'h00002000, {5'd1, 5'd0, 5'd0, 3'd2}};

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb_en = 1'b1;

        // Post-reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_flags", 32'({beq, bneq, blt, bltu, bge, bgeu, jmp, out_illegal}), 32'd0);
        chk("rst_imms", out_imm_b | out_imm_j, 32'd0);
        @(posedge clk);
        #1;

        // Pass-through with out_ready held high
        out_ready = 1'b1;
        push(32'h0, 32'h00000013);
        push(32'h4, 32'h00000013);
        push(32'h8, 32'h00000013);
        wait_empty("t1_drain");

        // Stall: fill to DEPTH, third entry held off
        out_ready = 1'b0;
        push(32'h10, 32'h11111113);
        push(32'h14, 32'h22222213);
        in_valid = 1'b1;
        in_pc    = 32'h18;
        in_instr = 32'h33333313;
        repeat (2) @(negedge clk);
        chk("t2_count_full", 32'(count), 32'(DEPTH));
        chk("t2_in_ready_full", 32'(in_ready), 32'd0);
        chk("t2_head_stable", out_pc, 32'h10);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push(32'h18, 32'h33333313);
        wait_empty("t2_drain");

        // Decode table, one entry at a time
        out_ready = 1'b0;
        for (int k = 0; k < NV; k++) begin
            push(32'h100 + 32'(k) * 4, vec[k].instr);
            out_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("dec%0d_flags", k),
                32'({beq, bneq, blt, bltu, bge, bgeu, jmp, out_illegal}), 32'(vec[k].flags));
            chk($sformatf("dec%0d_imm_b", k), out_imm_b, vec[k].imm_b);
            chk($sformatf("dec%0d_imm_j", k), out_imm_j, vec[k].imm_j);
            chk($sformatf("dec%0d_fields", k),
                32'({out_rd, out_rs1, out_rs2, out_funct3}), 32'(vec[k].fields));
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end

        // Flush with a full buffer and a same-cycle push
        push(32'h300, 32'h00000013);
        push(32'h304, 32'h00000013);
        @(negedge clk);
        chk("t4_count_pre", 32'(count), 32'd2);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_pc    = 32'h308;
        in_instr = 32'h00000013;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_count_post", 32'(count), 32'd0);
        chk("t4_valid_post", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        push(32'h30C, 32'h00000013);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_next_pc", out_pc, 32'h30C);
        wait_empty("t4_drain");

        // Stream across pointer wrap with random stalls
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    push(32'h200 + 32'(i) * 4, $urandom);
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_empty("t5_drain");

        // Reset mid-stream
        out_ready = 1'b0;
        push(32'h400, 32'hFE000EE3);
        @(negedge clk);
        chk("t6_count_pre", 32'(count), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_out_pc", out_pc, 32'd0);
        chk("t6_out_instr", out_instr, 32'd0);
        chk("t6_flags", 32'({beq, bneq, blt, bltu, bge, bgeu, jmp, out_illegal}), 32'd0);
        chk("t6_imm_b", out_imm_b, 32'd0);
        chk("t6_imm_j", out_imm_j, 32'd0);
        chk("t6_fields", 32'({out_rd, out_rs1, out_rs2, out_funct3}), 32'd0);

        @(posedge clk);
        #1;
        sb_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
